// File: rtl/signal_lamp_monitor.sv
// Lamp decoder and conflict monitor for an 8-lane intersection (4 through, 4 left).
// Optional stuck-code watchdog: define SIGNAL_LAMP_MONITOR_WATCHDOG_EN.
module signal_lamp_monitor #(
    parameter int FLASH_HALF     = 4,
    parameter int MIN_YELLOW     = 2,
    parameter int STARTUP_CYCLES = 8,
    parameter int WDOG_CYCLES    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] light_code,
    input  logic        clear_fault,
    output logic [7:0]  lamp_red,
    output logic [7:0]  lamp_yellow,
    output logic [7:0]  lamp_green,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [2:0]  fault_lane
);
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [1:0]  CODE_GREEN  = 2'b00;
    localparam logic [1:0]  CODE_YELLOW = 2'b01;
    localparam logic [1:0]  CODE_RED    = 2'b10;
    localparam logic [1:0]  CODE_FLASH  = 2'b11;
    localparam logic [15:0] ALL_RED     = 16'hAAAA;
    localparam logic [7:0]  NS_MASK     = 8'h55;
    localparam logic [7:0]  EW_MASK     = 8'hAA;

    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int IW = $clog2(STARTUP_CYCLES + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [IW-1:0] INIT_LAST  = IW'(STARTUP_CYCLES - 1);
    localparam logic [YW-1:0] YEL_MIN    = YW'(MIN_YELLOW);

    state_t          state_q, state_d;
    logic [15:0]     cur_q, prev_q;
    logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
    logic            flash_q, flash_d;
    logic [IW-1:0]   init_cnt_q, init_cnt_d;
    logic [YW-1:0]   ydwell_q [8];
    logic [YW-1:0]   ydwell_d [8];
    logic [2:0]      fault_code_q, fault_code_d;
    logic [2:0]      fault_lane_q, fault_lane_d;
    logic            fault_q, fault_d;
    logic [7:0]      lamp_red_q, lamp_red_d;
    logic [7:0]      lamp_yellow_q, lamp_yellow_d;
    logic [7:0]      lamp_green_q, lamp_green_d;

    logic [7:0]      green_s, gy_s, skip_s, short_s, conf_s;
    logic [3:0]      left_s;
    logic            all_red_s;
    logic            wdog_trip_s;
    logic [2:0]      viol_code_s, viol_lane_s;

    function automatic logic [2:0] lowest_lane(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = mask[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    // Green or yellow on the through lane that opposes a left turn.
    function automatic logic opp_busy(input logic [1:0] code);
        return (code == CODE_GREEN) || (code == CODE_YELLOW);
    endfunction

    // Per-lane violation masks and the prioritised fault selection.
    always_comb begin
        green_s = 8'h00;
        gy_s    = 8'h00;
        skip_s  = 8'h00;
        short_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            green_s[i] = (cur_q[2*i +: 2] == CODE_GREEN);
            gy_s[i]    = green_s[i] || (cur_q[2*i +: 2] == CODE_FLASH);
            skip_s[i]  = (prev_q[2*i +: 2] == CODE_GREEN) && (cur_q[2*i +: 2] == CODE_RED);
            short_s[i] = (prev_q[2*i +: 2] == CODE_YELLOW) && (cur_q[2*i +: 2] == CODE_RED)
                         && (ydwell_q[i] < YEL_MIN);
        end
        if (((|(green_s & NS_MASK)) && (|(gy_s & EW_MASK))) ||
            ((|(green_s & EW_MASK)) && (|(gy_s & NS_MASK)))) begin
            conf_s = green_s;
        end else begin
            conf_s = 8'h00;
        end
        left_s[0]   = green_s[4] && opp_busy(cur_q[5:4]);
        left_s[1]   = green_s[5] && opp_busy(cur_q[7:6]);
        left_s[2]   = green_s[6] && opp_busy(cur_q[1:0]);
        left_s[3]   = green_s[7] && opp_busy(cur_q[3:2]);
        conf_s[7:4] = conf_s[7:4] | left_s;
        conf_s[2]   = conf_s[2] | (left_s[0] & green_s[2]);
        conf_s[3]   = conf_s[3] | (left_s[1] & green_s[3]);
        conf_s[0]   = conf_s[0] | (left_s[2] & green_s[0]);
        conf_s[1]   = conf_s[1] | (left_s[3] & green_s[1]);
        all_red_s   = (cur_q == ALL_RED);

        if (|conf_s) begin
            viol_code_s = 3'd3;
            viol_lane_s = lowest_lane(conf_s);
        end else if (|skip_s) begin
            viol_code_s = 3'd1;
            viol_lane_s = lowest_lane(skip_s);
        end else if (|short_s) begin
            viol_code_s = 3'd2;
            viol_lane_s = lowest_lane(short_s);
        end else if (wdog_trip_s) begin
            viol_code_s = 3'd4;
            viol_lane_s = 3'd0;
        end else begin
            viol_code_s = 3'd0;
            viol_lane_s = 3'd0;
        end
    end

    // Flash generator, yellow dwell counters and the state machine.
    always_comb begin
        flash_cnt_d  = (flash_cnt_q == FLASH_LAST) ? {FW{1'b0}} : flash_cnt_q + FW'(1);
        flash_d      = (flash_cnt_q == FLASH_LAST) ? ~flash_q : flash_q;
        for (int i = 0; i < 8; i++) begin
            if (cur_q[2*i +: 2] == CODE_YELLOW) begin
                ydwell_d[i] = (ydwell_q[i] == YEL_MIN) ? YEL_MIN : ydwell_q[i] + YW'(1);
            end else begin
                ydwell_d[i] = {YW{1'b0}};
            end
        end
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        fault_code_d = fault_code_q;
        fault_lane_d = fault_lane_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = S_RUN;
                    init_cnt_d = {IW{1'b0}};
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            S_RUN: begin
                if (viol_code_s != 3'd0) begin
                    state_d      = S_FAULT;
                    fault_code_d = viol_code_s;
                    fault_lane_d = viol_lane_s;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                if (clear_fault && all_red_s) begin
                    state_d      = S_INIT;
                    init_cnt_d   = {IW{1'b0}};
                    fault_code_d = 3'd0;
                    fault_lane_d = 3'd0;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d      = S_INIT;
                init_cnt_d   = {IW{1'b0}};
                fault_code_d = 3'd0;
                fault_lane_d = 3'd0;
            end
        endcase
    end

    // Lamp drives follow the state being entered so a fault shows with its flag.
    always_comb begin
        lamp_red_d    = 8'h00;
        lamp_yellow_d = 8'h00;
        lamp_green_d  = 8'h00;
        fault_d       = (state_d == S_FAULT);
        case (state_d)
            S_INIT: begin
                lamp_red_d = 8'hFF;
            end
            S_RUN: begin
                for (int i = 0; i < 8; i++) begin
                    case (cur_q[2*i +: 2])
                        CODE_GREEN:  lamp_green_d[i]  = 1'b1;
                        CODE_YELLOW: lamp_yellow_d[i] = 1'b1;
                        CODE_RED:    lamp_red_d[i]    = 1'b1;
                        CODE_FLASH:  lamp_yellow_d[i] = flash_q;
                        default:     lamp_red_d[i]    = 1'b1;
                    endcase
                end
            end
            S_FAULT: begin
                lamp_red_d = {8{flash_q}};
            end
            default: begin
                lamp_red_d = 8'hFF;
            end
        endcase
    end

`ifdef SIGNAL_LAMP_MONITOR_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          stall_s;

    // Count RUN cycles with a frozen code word that is not all red.
    always_comb begin
        stall_s     = (state_q == S_RUN) && (cur_q == prev_q) && (cur_q != ALL_RED);
        if (stall_s) begin
            wdog_d = wdog_q + WW'(1);
        end else begin
            wdog_d = {WW{1'b0}};
        end
        wdog_trip_s = stall_s && (wdog_q == WDOG_LAST);
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= {WW{1'b0}};
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // Watchdog compiled out; the parameter stays for a uniform interface.
    assign wdog_trip_s = (WDOG_CYCLES < 0);
`endif

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            cur_q         <= ALL_RED;
            prev_q        <= ALL_RED;
            flash_cnt_q   <= {FW{1'b0}};
            flash_q       <= 1'b0;
            init_cnt_q    <= {IW{1'b0}};
            for (int i = 0; i < 8; i++) begin
                ydwell_q[i] <= {YW{1'b0}};
            end
            fault_code_q  <= 3'd0;
            fault_lane_q  <= 3'd0;
            fault_q       <= 1'b0;
            lamp_red_q    <= 8'hFF;
            lamp_yellow_q <= 8'h00;
            lamp_green_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            cur_q         <= light_code;
            prev_q        <= cur_q;
            flash_cnt_q   <= flash_cnt_d;
            flash_q       <= flash_d;
            init_cnt_q    <= init_cnt_d;
            for (int i = 0; i < 8; i++) begin
                ydwell_q[i] <= ydwell_d[i];
            end
            fault_code_q  <= fault_code_d;
            fault_lane_q  <= fault_lane_d;
            fault_q       <= fault_d;
            lamp_red_q    <= lamp_red_d;
            lamp_yellow_q <= lamp_yellow_d;
            lamp_green_q  <= lamp_green_d;
        end
    end

    assign lamp_red    = lamp_red_q;
    assign lamp_yellow = lamp_yellow_q;
    assign lamp_green  = lamp_green_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_lane  = fault_lane_q;
endmodule

// File: tb/tb_signal_lamp_monitor.sv
// Scoreboard bench for signal_lamp_monitor: a lane-level model predicts every edge.
module tb_signal_lamp_monitor;
    localparam int FH = 4;
    localparam int MY = 2;
    localparam int SC = 8;
    localparam logic [15:0] AR = 16'hAAAA;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] light_code = 16'hAAAA;
    logic        clear_fault = 1'b0;
    logic [7:0]  lamp_red, lamp_yellow, lamp_green;
    logic        fault;
    logic [2:0]  fault_code, fault_lane;

    signal_lamp_monitor #(
        .FLASH_HALF(FH), .MIN_YELLOW(MY), .STARTUP_CYCLES(SC), .WDOG_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .light_code(light_code), .clear_fault(clear_fault),
        .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
        .fault(fault), .fault_code(fault_code), .fault_lane(fault_lane)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    logic [30:0] exp_q[$];
    logic [30:0] mon_w;

    // Model: mode 0 = start-up, 1 = monitoring, 2 = latched fault
    int m_mode, m_edges, m_init_left, m_fcode, m_flane;
    int m_cur[8], m_prev[8], m_yrun[8];

    function automatic logic [30:0] dut_out();
        return {lamp_red, lamp_yellow, lamp_green, fault, fault_code, fault_lane};
    endfunction

    task automatic check(input string name, input logic [30:0] got, input logic [30:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got red=%h yel=%h grn=%h fault=%b code=%0d lane=%0d, expected red=%h yel=%h grn=%h fault=%b code=%0d lane=%0d",
                     name, got[30:23], got[22:15], got[14:7], got[6], got[5:3], got[2:0],
                     want[30:23], want[22:15], want[14:7], want[6], want[5:3], want[2:0]);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_edges = 0; m_init_left = SC; m_fcode = 0; m_flane = 0;
        for (int i = 0; i < 8; i++) begin
            m_cur[i] = 2; m_prev[i] = 2; m_yrun[i] = 0;
        end
    endtask

    function automatic int lowest(input bit [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic judge(output int code, output int lane);
        bit [7:0] conf, skip, shrt;
        int opp[4] = '{2, 3, 0, 1};
        conf = '0; skip = '0; shrt = '0;
        for (int a = 0; a < 8; a += 2)
            for (int b = 1; b < 8; b += 2)
                if ((m_cur[a] == 0 && (m_cur[b] == 0 || m_cur[b] == 3)) ||
                    (m_cur[b] == 0 && (m_cur[a] == 0 || m_cur[a] == 3))) begin
                    if (m_cur[a] == 0) conf[a] = 1'b1;
                    if (m_cur[b] == 0) conf[b] = 1'b1;
                end
        for (int k = 0; k < 4; k++)
            if (m_cur[4+k] == 0 && (m_cur[opp[k]] == 0 || m_cur[opp[k]] == 1)) begin
                conf[4+k] = 1'b1;
                if (m_cur[opp[k]] == 0) conf[opp[k]] = 1'b1;
            end
        for (int i = 0; i < 8; i++) begin
            skip[i] = (m_prev[i] == 0 && m_cur[i] == 2);
            shrt[i] = (m_prev[i] == 1 && m_cur[i] == 2 && m_yrun[i] < MY);
        end
        if (conf != 0)      begin code = 3; lane = lowest(conf); end
        else if (skip != 0) begin code = 1; lane = lowest(skip); end
        else if (shrt != 0) begin code = 2; lane = lowest(shrt); end
        else                begin code = 0; lane = 0; end
    endtask

    task automatic model_edge(input bit rst_n_i, input logic [15:0] lc, input bit clr,
                              output logic [30:0] want);
        int phase, vc, vl;
        bit all_red;
        logic [7:0] r, y, g;
        if (!rst_n_i) begin
            model_reset();
            want = {8'hFF, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0};
            return;
        end
        phase = (m_edges / FH) % 2;
        case (m_mode)
            0: begin
                m_init_left--;
                if (m_init_left == 0) m_mode = 1;
            end
            1: begin
                judge(vc, vl);
                if (vc != 0) begin m_mode = 2; m_fcode = vc; m_flane = vl; end
            end
            default: begin
                all_red = 1'b1;
                for (int i = 0; i < 8; i++) if (m_cur[i] != 2) all_red = 1'b0;
                if (clr && all_red) begin
                    m_mode = 0; m_init_left = SC; m_fcode = 0; m_flane = 0;
                end
            end
        endcase
        r = 8'h00; y = 8'h00; g = 8'h00;
        if (m_mode == 0) r = 8'hFF;
        else if (m_mode == 1) begin
            for (int i = 0; i < 8; i++)
                case (m_cur[i])
                    0:       g[i] = 1'b1;
                    1:       y[i] = 1'b1;
                    2:       r[i] = 1'b1;
                    default: y[i] = (phase == 1);
                endcase
        end else r = (phase == 1) ? 8'hFF : 8'h00;
        want = {r, y, g, (m_mode == 2), 3'(m_fcode), 3'(m_flane)};
        for (int i = 0; i < 8; i++) begin
            m_yrun[i] = (m_cur[i] == 1) ? m_yrun[i] + 1 : 0;
            m_prev[i] = m_cur[i];
            m_cur[i]  = int'(lc[2*i +: 2]);
        end
        m_edges++;
    endtask

    task automatic cyc(input logic [15:0] lc, input bit clr = 1'b0, input bit rst_n_i = 1'b1);
        logic [30:0] want;
        @(negedge clk);
        reset = rst_n_i; light_code = lc; clear_fault = clr;
        if (!rst_n_i) begin
            #1;
            check("async reset", dut_out(), {8'hFF, 16'h0000, 1'b0, 6'h00});
        end
        model_edge(rst_n_i, lc, clr, want);
        exp_q.push_back(want);
    endtask

    function automatic logic [15:0] with_lane(input logic [15:0] base, input int lane,
                                              input logic [1:0] code);
        logic [15:0] v;
        v = base;
        v[2*lane +: 2] = code;
        return v;
    endfunction

    task automatic recover();
        repeat (2) cyc(AR);
        cyc(AR, 1'b1);
        repeat (SC + 2) cyc(AR);
    endtask

    task automatic random_phase(input int n);
        int drv[8];
        int owner;
        bit clr;
        logic [15:0] lc;
        for (int i = 0; i < 8; i++) drv[i] = 2;
        for (int c = 0; c < n; c++) begin
            owner = (c / 48) % 2;
            clr = 1'b0;
            if (m_mode == 2) begin
                if ($urandom_range(3) == 0) for (int i = 0; i < 8; i++) drv[i] = 2;
                clr = ($urandom_range(3) == 0);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if ((i % 2) != owner) begin
                        if (drv[i] == 0 || drv[i] == 3) drv[i] = 1;
                        else if (drv[i] == 1 && $urandom_range(1) == 1) drv[i] = 2;
                    end else if ($urandom_range(9) < 3) begin
                        case (drv[i])
                            0:       drv[i] = 1;
                            1:       drv[i] = 2;
                            2:       drv[i] = ($urandom_range(4) == 0) ? 3 : 0;
                            default: drv[i] = 2;
                        endcase
                    end
                    if ($urandom_range(99) == 0) drv[i] = int'($urandom_range(3));
                end
            end
            for (int i = 0; i < 8; i++) lc[2*i +: 2] = 2'(drv[i]);
            cyc(lc, clr);
        end
    endtask

    // Monitor: one expected output word per active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_w = exp_q.pop_front();
                edge_no++;
                check($sformatf("edge %0d", edge_no), dut_out(), mon_w);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cyc(AR, 1'b0, 1'b0);
        repeat (SC + 4) cyc(AR);
        // Normal through-N cycle: green, yellow, red.
        repeat (5) cyc(with_lane(AR, 0, 2'b00));
        repeat (3) cyc(with_lane(AR, 0, 2'b01));
        repeat (4) cyc(AR);
        // Skipped yellow, then flashing-red fault display.
        repeat (3) cyc(with_lane(AR, 0, 2'b00));
        repeat (12) cyc(AR);
        // Clear refused while N is green, then accepted with all red.
        cyc(with_lane(AR, 0, 2'b00));
        cyc(with_lane(AR, 0, 2'b00), 1'b1);
        recover();
        // Crossing greens, then left turn against oncoming yellow.
        repeat (4) cyc(with_lane(with_lane(AR, 0, 2'b00), 1, 2'b00));
        recover();
        repeat (4) cyc(with_lane(with_lane(AR, 4, 2'b00), 2, 2'b01));
        recover();
        // Flashing yellow on E-left.
        repeat (20) cyc(with_lane(AR, 5, 2'b11));
        repeat (2) cyc(AR);
        // Fault, then reset pulse mid-fault.
        repeat (2) cyc(with_lane(AR, 0, 2'b00));
        repeat (5) cyc(AR);
        repeat (2) cyc(AR, 1'b0, 1'b0);
        repeat (SC + 3) cyc(AR);
        random_phase(1500);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
